// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small FIFO of fetched words, redirect flush and halt
module fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_f,
  output logic [15:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        br_taken,
  input  logic [15:0] br_addr,
  input  logic        halt,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [31:0] ir_data,
  output logic [15:0] ir_pc,
  output logic [2:0]  q_count
);
  localparam int PW = DEPTH == 4 ? 2 : 1;
  localparam logic [2:0] FULL = 3'(DEPTH);
  logic [15:0] fetch_pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [47:0] mem [DEPTH];
  logic push, pop;
  assign im_addr = fetch_pc;
  assign ir_valid = q_count != 3'd0;
  assign pop = ir_valid & ir_ready & ~br_taken;
  assign push = rst_f & ~br_taken & ~halt & (q_count != FULL | pop);
  // Gate the head so stale storage never leaks out when the queue is empty
  assign ir_data = ir_valid ? mem[rd_ptr][47:16] : 32'h0;
  assign ir_pc = ir_valid ? mem[rd_ptr][15:0] : 16'h0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {im_data, fetch_pc};
  end
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      fetch_pc <= RESET_PC;
      q_count <= 3'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (br_taken) begin
      fetch_pc <= br_addr;
      q_count <= 3'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push) fetch_pc <= fetch_pc + 16'd1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      q_count <= q_count + {2'b0, push} - {2'b0, pop};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a behavioural queue model
module tb_fetch_queue;
  localparam int DEPTH = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic clk = 1'b0;
  logic rst_f, br_taken, halt, ir_ready, ir_valid;
  logic [15:0] im_addr, br_addr, ir_pc;
  logic [31:0] im_data, ir_data;
  logic [2:0] q_count;
  logic [15:0] sb[$];
  logic [15:0] model_pc;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_data(im_data),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt), .ir_ready(ir_ready),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;
  assign im_data = 32'hA000_0000 + {16'h0, im_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic pop, push;
    logic [15:0] e;
    int sz;
    #1;
    sz = sb.size();
    chk("im_addr", 32'(im_addr), 32'(model_pc));
    chk("q_count", 32'(q_count), 32'(sz));
    chk("ir_valid", 32'(ir_valid), 32'(sz != 0));
    pop = rst_f && !br_taken && sz != 0 && ir_ready;
    if (pop) begin
      e = sb.pop_front();
      chk("ir_pc", 32'(ir_pc), 32'(e));
      chk("ir_data", ir_data, 32'hA000_0000 + {16'h0, e});
    end else if (sz == 0) begin
      chk("empty_pc", 32'(ir_pc), 32'h0);
      chk("empty_data", ir_data, 32'h0);
    end
    if (!rst_f) begin
      sb.delete();
      model_pc = RESET_PC;
    end else if (br_taken) begin
      sb.delete();
      model_pc = br_addr;
    end else begin
      push = !halt && (sz < DEPTH || pop);
      if (push) begin
        sb.push_back(model_pc);
        model_pc = model_pc + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy, input logic hlt);
    ir_ready = rdy;
    halt = hlt;
    repeat (n) cycle();
  endtask

  task automatic redirect(input logic [15:0] a);
    br_taken = 1'b1;
    br_addr = a;
    cycle();
    br_taken = 1'b0;
  endtask

  initial begin
    rst_f = 1'b0; br_taken = 1'b0; br_addr = 16'h0; halt = 1'b0; ir_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_pc = RESET_PC;
    sb.delete();
    rst_f = 1'b1;
    run(8, 1'b1, 1'b0);
    run(5, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    redirect(16'h0040);
    run(4, 1'b1, 1'b0);
    redirect(16'hFFFE);
    run(6, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    run(4, 1'b1, 1'b1);
    run(4, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    rst_f = 1'b0;
    cycle();
    rst_f = 1'b1;
    run(4, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      ir_ready = $urandom_range(0, 3) != 0;
      halt = $urandom_range(0, 5) == 0;
      br_taken = $urandom_range(0, 15) == 0;
      br_addr = 16'($urandom);
      rst_f = $urandom_range(0, 63) != 0;
      cycle();
    end
    br_taken = 1'b0;
    rst_f = 1'b1;
    run(4, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, default 2, number of queue entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_f  input  1  reset; synchronous and active-low.
REQ-005 im_addr  output  16  word address presented to instruction memory.
REQ-006 im_data  input  32  instruction word returned by instruction memory; valid in the same cycle as im_addr.
REQ-007 br_taken  input  1  redirect request from the execute stage.
REQ-008 br_addr  input  16  redirect target word address; sampled when br_taken=1.
REQ-009 halt  input  1  stop fetching when 1; queued entries still drain.
REQ-010 ir_ready  input  1  decoder accepts the head entry this cycle.
REQ-011 ir_valid  output  1  head entry present.
REQ-012 ir_data  output  32  head instruction word.
REQ-013 ir_pc  output  16  address the head instruction was fetched from.
REQ-014 q_count  output  3  number of occupied entries, 0..DEPTH.

Function
REQ-015 im_addr shall equal the internal fetch_pc register at all times (combinational).
REQ-016 push condition: rst_f=1, br_taken=0, halt=0, and (q_count<DEPTH or pop).
REQ-017 pop condition: ir_valid=1 and ir_ready=1 and br_taken=0.
REQ-018 On push: the pair {im_data, fetch_pc} shall be written at the tail; fetch_pc <= fetch_pc+1.
REQ-019 fetch_pc increment is modulo 2^16: 16'hFFFF shall wrap to 16'h0000 with no flag.
REQ-020 On pop: the head entry shall advance; the popped word shall appear on ir_data in the same cycle it is accepted.
REQ-021 Simultaneous push and pop when full: both shall occur and q_count shall be unchanged.
REQ-022 Simultaneous push and pop when empty is impossible, because pop requires ir_valid=1.
REQ-023 q_count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-024 ir_valid shall equal (q_count != 0).
REQ-025 When q_count=0, ir_data shall be 32'h0 and ir_pc shall be 16'h0.
REQ-026 When q_count>0, ir_data and ir_pc shall reflect the oldest entry; entries leave in FIFO order.
REQ-027 Redirect (br_taken=1) has highest priority over push, pop and halt.
REQ-028 On redirect, the edge shall flush all entries (q_count <= 0), set fetch_pc <= br_addr, and perform no push and no pop.
REQ-029 On the cycle after a redirect, im_addr shall be br_addr; the first push at the target may occur that cycle if halt=0.
REQ-030 halt=1 shall freeze fetch_pc and suppress push; pops shall continue normally.
REQ-031 Deasserting halt shall resume fetching at the frozen fetch_pc with no skipped or duplicated address.
REQ-032 Read/write pointers shall wrap modulo DEPTH; a full queue shall never overwrite an unread entry.
REQ-033 Throughput: with ir_ready held at 1 and no redirect or halt, one instruction shall be delivered per cycle after a 1-cycle fill latency.

Reset
REQ-034 While rst_f=0 at a rising edge: fetch_pc <= RESET_PC, q_count <= 0, pointers <= 0.
REQ-035 After reset: ir_valid=0, ir_data=32'h0, ir_pc=16'h0, im_addr=RESET_PC.
REQ-036 Reset shall override br_taken, halt and ir_ready; reset mid-operation discards all queued entries.
REQ-037 Entry storage need not be cleared on reset; no unread stale entry shall ever be visible on the outputs.

Verification
REQ-038 Stream: reset, memory word[n]=32'hA000_0000+n, ir_ready=1 -> ir_pc sequence 0,1,2,3 on consecutive cycles after the first, with ir_data matching each address.
REQ-039 Backpressure: ir_ready=0 for 5 cycles -> q_count saturates at DEPTH, im_addr stalls at 2, no entry is lost; then ir_ready=1 -> in-order delivery of 0,1,2,...
REQ-040 Redirect: full queue, br_taken=1 with br_addr=16'h0040 -> next cycle q_count=0, ir_valid=0, im_addr=16'h0040; following delivery ir_pc=16'h0040.
REQ-041 Wrap: redirect to 16'hFFFE, stream -> ir_pc sequence FFFE, FFFF, 0000, 0001.
REQ-042 Halt: halt=1 with q_count=2, ir_ready=1 -> drains 2 entries, then ir_valid=0 and im_addr frozen; halt=0 -> resumes at the frozen address.
REQ-043 Reset mid-stream: rst_f=0 for one edge with q_count=2 -> q_count=0, ir_valid=0, im_addr=RESET_PC on the following cycle.
